// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared op encodings and FSM state type for the multiply/divide unit
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mduOpType;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mduState;

    function automatic logic isMulDiv(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic isMult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational mult/div datapath producing the pending HI/LO pair
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hiNext,
    output logic [31:0] loNext,
    output logic        div0
);

    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        signedDiv;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prodS = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prodU = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps to 0x80000000 naturally.
    assign signedDiv = (op == MDU_DIV);
    assign dividend  = (signedDiv && a[31]) ? (32'd0 - a) : a;
    assign divisor   = (signedDiv && b[31]) ? (32'd0 - b) : b;
    assign quot      = (divisor == 32'd0) ? 32'd0 : (dividend / divisor);
    assign rem       = (divisor == 32'd0) ? 32'd0 : (dividend % divisor);

    always_comb begin
        hiNext = 32'd0;
        loNext = 32'd0;
        div0   = 1'b0;
        case (op)
            MDU_MULT: begin
                hiNext = prodS[63:32];
                loNext = prodS[31:0];
            end
            MDU_MULTU: begin
                hiNext = prodU[63:32];
                loNext = prodU[31:0];
            end
            MDU_DIV: begin
                loNext = (a[31] ^ b[31]) ? (32'd0 - quot) : quot;
                hiNext = a[31] ? (32'd0 - rem) : rem;
                div0   = (b == 32'd0);
            end
            MDU_DIVU: begin
                loNext = quot;
                hiNext = rem;
                div0   = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO and the busy stall signal
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mduState          state;
    mduState          stateNext;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hiPend;
    logic [31:0]      loPend;
    logic             div0Pend;
    logic [31:0]      hiNext;
    logic [31:0]      loNext;
    logic             div0;
    logic             launch;
    logic             commit;
    logic             mtHi;
    logic             mtLo;

    mdu_arith uArith (
        .op     (op),
        .a      (a),
        .b      (b),
        .hiNext (hiNext),
        .loNext (loNext),
        .div0   (div0)
    );

    always_comb begin
        stateNext = state;
        launch    = 1'b0;
        commit    = 1'b0;
        mtHi      = 1'b0;
        mtLo      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (isMulDiv(op)) begin
                        launch    = 1'b1;
                        stateNext = RUN;
                    end
                    mtHi = (op == MDU_MTHI);
                    mtLo = (op == MDU_MTLO);
                end
            end
            RUN: begin
                // Any start seen here is a hazard-unit violation and is dropped.
                if (cnt == CNT_W'(1)) begin
                    stateNext = IDLE;
                    commit    = !div0Pend;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hiPend   <= 32'd0;
            loPend   <= 32'd0;
            div0Pend <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            state <= stateNext;
            if (launch) begin
                hiPend   <= hiNext;
                loPend   <= loNext;
                div0Pend <= div0;
                cnt      <= isMult(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                hi <= hiPend;
                lo <= loPend;
            end
            if (mtHi) begin
                hi <= a;
            end
            if (mtLo) begin
                lo <= a;
            end
        end
    end

    assign busy = (state == RUN);

    always_comb begin
        rd_data = 32'd0;
        if (op == MDU_MFHI) begin
            rd_data = hi;
        end else if (op == MDU_MFLO) begin
            rd_data = lo;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl with directed mult/div/mthi/reset vectors
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0: busy, kind 1: hi/lo pair, kind 2: rd_data
    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] e0;
        logic [31:0] e1;
        string       name;
    } expT;

    expT sb[$];
    int  checks   = 0;
    int  failures = 0;
    bit  done     = 1'b0;

    task automatic push(input int c, input int k, input logic [31:0] e0, input logic [31:0] e1,
                        input string n);
        expT e;
        e.cyc  = c;
        e.kind = k;
        e.e0   = e0;
        e.e1   = e1;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle, compare all expectations tagged with the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    checks++;
                    case (sb[i].kind)
                        0: if (busy !== sb[i].e0[0]) begin
                            failures++;
                            $display("FAIL %s cycle %0d: busy=%0b required %0b",
                                     sb[i].name, cyc, busy, sb[i].e0[0]);
                        end
                        1: if (hi !== sb[i].e0 || lo !== sb[i].e1) begin
                            failures++;
                            $display("FAIL %s cycle %0d: hi=%h lo=%h required hi=%h lo=%h",
                                     sb[i].name, cyc, hi, lo, sb[i].e0, sb[i].e1);
                        end
                        default: if (rd_data !== sb[i].e0) begin
                            failures++;
                            $display("FAIL %s cycle %0d: rd_data=%h required %h",
                                     sb[i].name, cyc, rd_data, sb[i].e0);
                        end
                    endcase
                    sb.delete(i);
                end
            end
            if (done) break;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic runOp(input logic [3:0] opv, input logic [31:0] av, input logic [31:0] bv,
                         input int n, input logic [31:0] eh, input logic [31:0] el,
                         input string name);
        int c0;
        c0    = cyc;
        start = 1'b1;
        op    = opv;
        a     = av;
        b     = bv;
        push(c0, 0, 32'd0, 32'd0, {name, "_busy0"});
        for (int k = 1; k <= n; k++) push(c0 + k, 0, 32'd1, 32'd0, {name, "_busy"});
        push(c0 + n + 1, 0, 32'd0, 32'd0, {name, "_done"});
        push(c0 + n + 1, 1, eh, el, {name, "_result"});
        step();
        start = 1'b0;
        op    = MDU_NONE;
        repeat (n) step();
    endtask

    task automatic mtOp(input logic [3:0] opv, input logic [31:0] av, input logic [31:0] eh,
                        input logic [31:0] el, input string name);
        int c0;
        c0    = cyc;
        start = 1'b1;
        op    = opv;
        a     = av;
        push(c0 + 1, 0, 32'd0, 32'd0, {name, "_nobusy"});
        push(c0 + 1, 1, eh, el, {name, "_result"});
        step();
        start = 1'b0;
        op    = MDU_NONE;
    endtask

    initial begin
        int c0;
        reset = 1'b1;
        start = 1'b0;
        op    = MDU_NONE;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) step();
        reset = 1'b0;
        push(cyc, 0, 32'd0, 32'd0, "rst_busy");
        push(cyc, 1, 32'd0, 32'd0, "rst_hilo");
        step();

        runOp(MDU_MULT,  32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult_neg");
        runOp(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, "multu");
        runOp(MDU_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        runOp(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf");
        mtOp(MDU_MTHI, 32'h00001234, 32'h00001234, 32'h80000000, "mthi");
        runOp(MDU_DIVU,  32'd7, 32'd0, 10, 32'h00001234, 32'h80000000, "divu_by0");

        op = MDU_MFHI;
        push(cyc, 2, 32'h00001234, 32'd0, "mfhi");
        step();
        op = MDU_MFLO;
        push(cyc, 2, 32'h80000000, 32'd0, "mflo");
        step();
        op = MDU_MTHI;
        push(cyc, 2, 32'd0, 32'd0, "rd_other");
        step();

        start = 1'b1;
        op    = MDU_NONE;
        a     = 32'hDEADBEEF;
        push(cyc + 1, 0, 32'd0, 32'd0, "none_busy");
        push(cyc + 1, 1, 32'h00001234, 32'h80000000, "none_hilo");
        step();
        start = 1'b0;

        mtOp(MDU_MTLO, 32'h0000CAFE, 32'h00001234, 32'h0000CAFE, "mtlo");

        // Reset mid-RUN discards the pending product.
        c0    = cyc;
        start = 1'b1;
        op    = MDU_MULT;
        a     = 32'd3;
        b     = 32'd4;
        for (int k = 1; k <= 3; k++) push(c0 + k, 0, 32'd1, 32'd0, "rstmid_busy");
        step();
        start = 1'b0;
        op    = MDU_NONE;
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 4; k <= 8; k++) begin
            push(c0 + k, 0, 32'd0, 32'd0, "rstmid_idle");
            push(c0 + k, 1, 32'd0, 32'd0, "rstmid_hilo");
        end
        repeat (5) step();

        // Back-to-back: DIVU then MULTU in the very cycle the divide result appears.
        runOp(MDU_DIVU, 32'd9, 32'd4, 10, 32'd1, 32'd2, "divu_9_4");
        c0    = cyc;
        start = 1'b1;
        op    = MDU_MULTU;
        a     = 32'd5;
        b     = 32'd6;
        push(c0, 0, 32'd0, 32'd0, "b2b_busy0");
        for (int k = 1; k <= 5; k++) push(c0 + k, 0, 32'd1, 32'd0, "b2b_busy");
        push(c0 + 2, 1, 32'd1, 32'd2, "b2b_hold");
        push(c0 + 6, 0, 32'd0, 32'd0, "b2b_done");
        push(c0 + 6, 1, 32'd0, 32'd30, "b2b_result");
        step();
        $display("note: start injected while busy (hazard violation), expecting no effect");
        op = MDU_MULT;
        a  = 32'h0000FFFF;
        b  = 32'h0000FFFF;
        step();
        start = 1'b0;
        op    = MDU_NONE;
        repeat (6) step();

        done = 1'b1;
        repeat (2) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
